// File: rtl/obj_pixel_serializer_if.sv
// obj_pixel_serializer_if: control, graphics and pixel signals of one TIA object serializer
interface obj_pixel_serializer_if #(
  parameter int GFX_W = 8,
  parameter int POS_W = 8
);
  logic             pix_en;
  logic             resp;
  logic             hmove;
  logic [3:0]       hm_val;
  logic [2:0]       obj_size;
  logic             reflect;
  logic             gfx_wr;
  logic [GFX_W-1:0] gfx_in;
  logic             gfx_commit;
  logic             vdel;
  logic             pixel_on;
  logic [POS_W-1:0] pos_out;
  modport master (
    output pix_en, resp, hmove, hm_val, obj_size, reflect, gfx_wr, gfx_in, gfx_commit, vdel,
    input  pixel_on, pos_out
  );
  modport slave (
    input  pix_en, resp, hmove, hm_val, obj_size, reflect, gfx_wr, gfx_in, gfx_commit, vdel,
    output pixel_on, pos_out
  );
endinterface

// File: rtl/obj_pixel_serializer.sv
// obj_pixel_serializer: position counter, motion, copy replication and stretched graphic shift-out
module obj_pixel_serializer #(
  parameter int GFX_W       = 8,
  parameter int LINE_PIXELS = 160,
  parameter int POS_W       = 8
) (
  input logic clk,
  input logic rst_n,
  obj_pixel_serializer_if.slave b
);
  localparam int BW = GFX_W > 1 ? $clog2(GFX_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(GFX_W - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LINE_PIXELS - 1);
  localparam logic signed [POS_W+1:0] LP = (POS_W + 2)'(LINE_PIXELS);
  typedef enum logic {IDLE, DRAW} state_t;
  state_t state, state_nx;
  logic [POS_W-1:0] pos, pos_nx, pos_mv;
  logic [GFX_W-1:0] gfx_a, gfx_b, sr, sr_nx;
  logic [BW-1:0] bit_q, bit_nx, nb;
  logic [1:0] sub, sub_nx, smax;
  logic pix, pix_nx, hit, start;
  logic signed [POS_W+1:0] mv;
  assign b.pixel_on = pix;
  assign b.pos_out = pos;
  // Motion result spans -7..LINE_PIXELS+8 before folding back into the line
  assign mv = $signed({2'b00, pos}) + $signed({{(POS_W+1){1'b0}}, b.pix_en})
            - $signed({{(POS_W-2){b.hm_val[3]}}, b.hm_val});
  assign pos_mv = mv[POS_W+1] ? POS_W'(mv + LP) : (mv >= LP ? POS_W'(mv - LP) : POS_W'(mv));
  assign pos_nx = b.resp ? '0 : b.hmove ? pos_mv : b.pix_en ? (pos == LAST_POS ? '0 : pos + 1'b1) : pos;
  assign hit = pos == '0
             || (pos == POS_W'(16) && (b.obj_size == 3'd1 || b.obj_size == 3'd3))
             || (pos == POS_W'(32) && (b.obj_size == 3'd2 || b.obj_size == 3'd3 || b.obj_size == 3'd6))
             || (pos == POS_W'(64) && (b.obj_size == 3'd4 || b.obj_size == 3'd6));
  assign start = b.pix_en && !b.resp && !b.hmove && hit;
  assign smax = b.obj_size == 3'd7 ? 2'd3 : b.obj_size == 3'd5 ? 2'd1 : 2'd0;
  assign nb = bit_q + 1'b1;
  always_comb begin
    state_nx = state;
    bit_nx = bit_q;
    sub_nx = sub;
    sr_nx = sr;
    pix_nx = pix;
    if (start) begin
      state_nx = DRAW;
      sr_nx = b.vdel ? gfx_b : gfx_a;
      bit_nx = '0;
      sub_nx = '0;
      pix_nx = b.reflect ? sr_nx[0] : sr_nx[GFX_W-1];
    end else if (b.pix_en && state == DRAW) begin
      if (sub < smax) sub_nx = sub + 1'b1;
      else if (bit_q == LAST) begin
        state_nx = IDLE;
        sub_nx = '0;
        bit_nx = '0;
        pix_nx = 1'b0;
      end else begin
        sub_nx = '0;
        bit_nx = nb;
        pix_nx = sr[b.reflect ? nb : LAST - nb];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pos <= '0;
      gfx_a <= '0;
      gfx_b <= '0;
      sr <= '0;
      bit_q <= '0;
      sub <= '0;
      pix <= 1'b0;
    end else begin
      state <= state_nx;
      pos <= pos_nx;
      if (b.gfx_wr) gfx_a <= b.gfx_in;
      if (b.gfx_commit) gfx_b <= gfx_a;
      sr <= sr_nx;
      bit_q <= bit_nx;
      sub <= sub_nx;
      pix <= pix_nx;
    end
  end
endmodule

// File: tb/tb_obj_pixel_serializer.sv
// tb_obj_pixel_serializer: directed checks of position, copies, stretch, reflect and buffering
module tb_obj_pixel_serializer;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  obj_pixel_serializer_if #(.GFX_W(8), .POS_W(8)) b();
  obj_pixel_serializer #(.GFX_W(8), .LINE_PIXELS(160), .POS_W(8)) dut (.clk(clk), .rst_n(rst_n), .b(b));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_line(input string tag, input int n, input logic [159:0] m, input int poke);
    b.pix_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      b.gfx_commit = (k == poke);
      tick();
      chk($sformatf("%s px%0d", tag, k), {31'b0, b.pixel_on}, {31'b0, m[k]});
    end
    b.pix_en = 1'b0;
    b.gfx_commit = 1'b0;
  endtask
  task automatic write_a(input logic [7:0] v, input logic commit);
    b.gfx_wr = 1'b1;
    b.gfx_in = v;
    b.gfx_commit = commit;
    tick();
    b.gfx_wr = 1'b0;
    b.gfx_commit = 1'b0;
  endtask
  task automatic pulse_resp();
    b.resp = 1'b1;
    tick();
    b.resp = 1'b0;
  endtask
  task automatic move(input logic [3:0] v, input logic pe);
    b.hmove = 1'b1;
    b.hm_val = v;
    b.pix_en = pe;
    tick();
    b.hmove = 1'b0;
    b.pix_en = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    b.pix_en = 0; b.resp = 0; b.hmove = 0; b.hm_val = 0; b.obj_size = 0; b.reflect = 0;
    b.gfx_wr = 0; b.gfx_in = 0; b.gfx_commit = 0; b.vdel = 0;
    tick();
    tick();
    chk("reset pixel", {31'b0, b.pixel_on}, 32'd0);
    chk("reset pos", {24'b0, b.pos_out}, 32'd0);
    rst_n = 1'b1;
    write_a(8'hA5, 1'b0);
    pulse_resp();
    chk("resp pos", {24'b0, b.pos_out}, 32'd0);
    run_line("size0 A5", 160, 160'hA5, -1);
    chk("wrap pos", {24'b0, b.pos_out}, 32'd0);
    b.obj_size = 3'd3;
    write_a(8'hFF, 1'b0);
    run_line("size3 FF", 160, 160'hFF00FF00FF, -1);
    b.obj_size = 3'd7;
    write_a(8'h80, 1'b0);
    run_line("size7 fwd", 160, 160'hF, -1);
    b.reflect = 1'b1;
    run_line("size7 refl", 160, 160'hF000_0000, -1);
    b.reflect = 1'b0;
    b.obj_size = 3'd5;
    write_a(8'hC0, 1'b0);
    run_line("size5 C0", 16, 160'hF, -1);
    b.obj_size = 3'd0;
    write_a(8'hFF, 1'b0);
    pulse_resp();
    move(4'd0, 1'b1);
    chk("hmove+pix pos", {24'b0, b.pos_out}, 32'd1);
    chk("no start on hmove", {31'b0, b.pixel_on}, 32'd0);
    move(4'd7, 1'b1);
    chk("hmove wrap neg", {24'b0, b.pos_out}, 32'd155);
    move(4'hC, 1'b0);
    chk("hmove -4", {24'b0, b.pos_out}, 32'd159);
    run_line("pos159 edge", 1, 160'h0, -1);
    chk("159 wraps", {24'b0, b.pos_out}, 32'd0);
    run_line("to pos10", 10, 160'hFF, -1);
    chk("pos10", {24'b0, b.pos_out}, 32'd10);
    move(4'd3, 1'b0);
    chk("hmove +3", {24'b0, b.pos_out}, 32'd7);
    move(4'd5, 1'b0);
    chk("hmove +5", {24'b0, b.pos_out}, 32'd2);
    move(4'h8, 1'b0);
    chk("hmove -8", {24'b0, b.pos_out}, 32'd10);
    b.vdel = 1'b1;
    pulse_resp();
    run_line("vdel B=0", 16, 160'h0, -1);
    write_a(8'hFF, 1'b1);
    write_a(8'h00, 1'b0);
    pulse_resp();
    run_line("vdel B=FF midcommit", 16, 160'hFF, 3);
    pulse_resp();
    run_line("vdel B=00", 16, 160'h0, -1);
    write_a(8'h5A, 1'b0);
    write_a(8'h3C, 1'b1);
    pulse_resp();
    run_line("wr+commit B", 16, 160'h5A, -1);
    b.vdel = 1'b0;
    pulse_resp();
    run_line("wr+commit A", 16, 160'h3C, -1);
    write_a(8'hFF, 1'b0);
    pulse_resp();
    run_line("pre reset", 3, 160'h7, -1);
    rst_n = 1'b0;
    b.pix_en = 1'b1;
    tick();
    b.pix_en = 1'b0;
    rst_n = 1'b1;
    chk("midcopy reset pixel", {31'b0, b.pixel_on}, 32'd0);
    chk("midcopy reset pos", {24'b0, b.pos_out}, 32'd0);
    run_line("A cleared", 5, 160'h0, -1);
    chk("pos5", {24'b0, b.pos_out}, 32'd5);
    b.resp = 1'b1;
    move(4'd3, 1'b1);
    b.resp = 1'b0;
    chk("resp beats hmove", {24'b0, b.pos_out}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
